reaction_timer_ctrl: RTL
========================

Name: reaction_timer_ctrl

Overview:
Controller that sequences a millisecond timing datapath to run a human reaction-time test. After a pseudo-random holdoff it asserts a "go" indicator, then measures in ms how long the user takes to respond. It detects false starts and timeouts. It sits between the debounced push-button inputs and the 7-segment/LED display logic on the 100 MHz board clock. It owns its own 1 ms tick prescaler so the measurement window is aligned to the go event.

Parameters:
CLK_PER_MS, 100000, clock cycles per 1 ms tick (100 MHz); benches override with a small value, e.g. 10.
MS_W, 11, width of ms result and counters.
MIN_DELAY_MS, 1000, fixed part of the holdoff before go.
MAX_MS, 1999, reaction timeout in ms; must be < 2**MS_W.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse, debounced upstream; arms a test.
resp  in  1  single-cycle pulse, debounced upstream; user response.
led_go  out  1  high while the user should respond.
busy  out  1  high in WAIT or GO.
result_ms  out  MS_W  last measured reaction time.
result_valid  out  1  high while result_ms holds a completed valid measurement.
early  out  1  a false start occurred in the last test.
timeout  out  1  the last test hit MAX_MS.
state_o  out  2  encoded current state, for debug and display.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Counters cleared. LFSR loaded with the seed.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1. Advances every clock in every state; never all-zero.
- Tick generator: counts 0..CLK_PER_MS-1 and pulses tick on the terminal count. Its count is cleared on every state entry, so the first tick comes exactly CLK_PER_MS cycles after entry.
- States: IDLE=0, WAIT=1, GO=2, DONE=3.
- IDLE: when start=1, go to WAIT next edge. Load delay_cnt = MIN_DELAY_MS + lfsr[9:0], giving 1000..2023. Clear early, timeout and result_valid. resp is ignored. If start and resp are asserted together, start wins.
- WAIT: delay_cnt decrements on each tick.
  - resp=1: go to DONE. Set early=1, result_ms=0, result_valid=0.
  - Tick while delay_cnt==1: go to GO, led_go=1, ms_cnt=0.
  - resp wins over a simultaneous final tick.
  - start is ignored.
- GO: ms_cnt increments on each tick.
  - resp=1: go to DONE. result_ms=ms_cnt as the value before any same-cycle increment. result_valid=1, led_go=0.
  - Tick while ms_cnt==MAX_MS-1: go to DONE. timeout=1, result_ms=MAX_MS, result_valid=0, led_go=0.
  - resp wins over a simultaneous timeout tick.
  - start is ignored.
- DONE: result_ms, early and timeout are held.
  - start=1: go to WAIT with the same load and clear actions as from IDLE. This allows back-to-back tests.
  - resp is ignored.
- Latency: every output is registered and updates on the edge that samples the causing input.
- ms_cnt never wraps, because MAX_MS bounds it. delay_cnt is MS_W+1 bits wide so 2023 fits.
- Asynchronous reset mid-test: immediate return to IDLE and all outputs 0, regardless of state.

Decomposition:
- Package reaction_pkg:
  - state_t enum (IDLE, WAIT, GO, DONE) as 2-bit logic.
  - LFSR_SEED and LFSR tap constants.
  - Default values for CLK_PER_MS and MAX_MS.
- Sub-module ms_tick_gen:
  - Ports clk, rst, clr, tick.
  - Parameter CLK_PER_MS.
  - Instantiated once.
- The FSM, LFSR and counters stay in the top module.

Test Plan:
- Reset released, no input for 50 cycles -> state_o=0, all outputs 0, LFSR never 0.
- CLK_PER_MS=10. Force the LFSR read so the delay is 1000 ms. Pulse start -> led_go rises exactly 10000 cycles after WAIT entry. Pulse resp 253 ticks after go -> result_ms=253, result_valid=1, state_o=3.
- Pulse start, then resp 5 ticks into WAIT -> early=1, result_ms=0, result_valid=0, led_go never asserted.
- Reach GO with no resp -> after 1999 ticks: timeout=1, result_ms=1999, led_go=0, state_o=3.
- In GO, resp on the same cycle as a tick with ms_cnt=40 -> result_ms=40. Resp on the same cycle as the timeout tick -> result_valid=1, timeout=0.
- Reset asserted mid-GO at ms 300 -> outputs 0 immediately and asynchronously. A following start runs a clean test. In DONE, start re-arms WAIT and clears early and timeout.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time test controller.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GO   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int CLK_PER_MS_DEF   = 100000;
  localparam int MIN_DELAY_MS_DEF = 1000;
  localparam int MAX_MS_DEF       = 1999;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: pulses tick once every CLK_PER_MS cycles, restartable via clr.
module ms_tick_gen
  import reaction_pkg::*;
#(
  parameter int CLK_PER_MS = CLK_PER_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_PER_MS - 1);

  logic [CNT_W-1:0] cnt_q;

  // tick is not masked by clr: the state that sees the final tick still needs it.
  assign tick = (cnt_q == TERM);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time test sequencer: random holdoff, go indicator, ms measurement,
// false-start and timeout detection. All outputs are registered.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_PER_MS   = CLK_PER_MS_DEF,
  parameter int MS_W         = 11,
  parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
  parameter int MAX_MS       = MAX_MS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            resp,
  output logic            led_go,
  output logic            busy,
  output logic [MS_W-1:0] result_ms,
  output logic            result_valid,
  output logic            early,
  output logic            timeout,
  output logic [1:0]      state_o
);

  localparam int DLY_W = MS_W + 1;

  state_t            state_q, state_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic [MS_W-1:0]   result_q, result_d;
  logic              valid_q, valid_d;
  logic              early_q, early_d;
  logic              timeout_q, timeout_d;
  logic              led_q, led_d;
  logic              busy_q;
  logic [15:0]       lfsr_q;
  logic              tick;
  logic              clr;

  ms_tick_gen #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  // Restart the ms prescaler on every state change so each window starts aligned.
  assign clr = (state_d != state_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      delay_q   <= '0;
      ms_q      <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      ms_q      <= ms_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
      led_q     <= led_d;
      busy_q    <= (state_d == WAIT) || (state_d == GO);
      lfsr_q    <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d   = state_q;
    delay_d   = delay_q;
    ms_d      = ms_q;
    result_d  = result_q;
    valid_d   = valid_q;
    early_d   = early_q;
    timeout_d = timeout_q;
    led_d     = led_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = WAIT;
          delay_d   = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[9:0]);
          early_d   = 1'b0;
          timeout_d = 1'b0;
          valid_d   = 1'b0;
        end
      end
      WAIT: begin
        if (resp) begin
          state_d  = DONE;
          early_d  = 1'b1;
          result_d = '0;
          valid_d  = 1'b0;
        end else if (tick) begin
          if (delay_q <= DLY_W'(1)) begin
            state_d = GO;
            led_d   = 1'b1;
            ms_d    = '0;
          end else begin
            delay_d = delay_q - DLY_W'(1);
          end
        end
      end
      GO: begin
        // resp is checked first so it wins over a coincident timeout tick.
        if (resp) begin
          state_d  = DONE;
          result_d = ms_q;
          valid_d  = 1'b1;
          led_d    = 1'b0;
        end else if (tick) begin
          if (ms_q == MS_W'(MAX_MS - 1)) begin
            state_d   = DONE;
            timeout_d = 1'b1;
            result_d  = MS_W'(MAX_MS);
            valid_d   = 1'b0;
            led_d     = 1'b0;
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign led_go       = led_q;
  assign busy         = busy_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
  assign early        = early_q;
  assign timeout      = timeout_q;
  assign state_o      = state_q;

endmodule
